mdu_iter: RTL

//  Iterative multiply/divide unit with HI/LO registers for the multicycle MIPS core.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_iter_if.sv | 26 ++
 rtl/mdu_step.sv | 31 +++
 rtl/mdu_iter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The op codes, FSM states and counter width helper are used by both the top level and the bench.
package mdu_pkg;

    localparam int MDU_N = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

    localparam int MDU_CNT_W = cnt_width(MDU_N);

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the multicycle control path and the multiply/divide unit.
// The control path drives the request as master, and the unit answers as slave.
interface mdu_iter_if #(
    parameter int N = 32
);
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] srcA;
    logic [N-1:0] srcB;
    logic         busy;
    logic         done;
    logic         divByZero;
    logic         illegal;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output start, op, srcA, srcB,
        input  busy, done, divByZero, illegal, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB,
        output busy, done, divByZero, illegal, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration on the 2N-bit accumulator.
// For multiply it performs an add-shift step; for divide it performs a restoring trial-subtract step.
module mdu_step #(
    parameter int N = 32
) (
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   operand,
    input  logic           isDiv,
    output logic [2*N-1:0] acc_next
);
    logic [N:0] sum;
    logic [N:0] trial;

    always_comb begin
        sum      = {1'b0, acc[2*N-1:N]} + {1'b0, operand};
        // The shifted partial remainder needs N+1 bits; the top bit is a borrow flag.
        trial    = acc[2*N-1:N-1] - {1'b0, operand};
        acc_next = acc;
        if (isDiv) begin
            if (!trial[N]) begin
                acc_next = {trial[N-1:0], acc[N-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*N-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[N-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*N-1:1]};
        end
    end
endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with architectural HI/LO registers.
// When MDU_DIV_EN is undefined, DIV/DIVU are rejected with an illegal/done pulse.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO complete here
// CALC   | one radix-2 step per clock, N steps
// FIX    | sign correction, HI/LO write, done
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int N = MDU_N
) (
    input  logic       clk,
    input  logic       rst,
    mdu_iter_if.slave  bus
);
    localparam int CW = cnt_width(N);

    mdu_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   opnd_q, opnd_d;
    logic [N-1:0]   a_q, a_d;
    logic           sa_q, sa_d;
    logic           sb_q, sb_d;
    logic           div_q, div_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;
    logic           ill_q, ill_d;

    logic [2*N-1:0] step_acc;
    logic           is_signed;
    logic [N-1:0]   abs_a;
    logic [N-1:0]   abs_b;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quo;
    logic [N-1:0]   rem;

    mdu_step #(.N(N)) u_step (
        .acc      (acc_q),
        .operand  (opnd_q),
        .isDiv    (div_q),
        .acc_next (step_acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_d       = a_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        div_d     = div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        ill_d     = 1'b0;

        // MULT and DIV have op[0]=0; the unsigned variants set it.
        is_signed = ~bus.op[0];
        abs_a     = (is_signed && bus.srcA[N-1]) ? -bus.srcA : bus.srcA;
        abs_b     = (is_signed && bus.srcB[N-1]) ? -bus.srcB : bus.srcB;

        prod      = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo       = (sa_q ^ sb_q) ? -acc_q[N-1:0] : acc_q[N-1:0];
        rem       = sa_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        MDU_MULT, MDU_MULTU,
                        MDU_DIV, MDU_DIVU: begin
                            dbz_d = 1'b0;
`ifdef MDU_DIV_EN
                            state_d = S_CALC;
`else
                            if (bus.op[1]) begin
                                ill_d  = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                state_d = S_CALC;
                            end
`endif
                            cnt_d  = '0;
                            div_d  = bus.op[1];
                            acc_d  = {{N{1'b0}}, abs_a};
                            opnd_d = abs_b;
                            a_d    = bus.srcA;
                            sa_d   = is_signed & bus.srcA[N-1];
                            sb_d   = is_signed & bus.srcB[N-1];
                        end
                        MDU_MTHI: begin
                            hi_d   = bus.srcA;
                            done_d = 1'b1;
                            dbz_d  = 1'b0;
                        end
                        MDU_MTLO: begin
                            lo_d   = bus.srcA;
                            done_d = 1'b1;
                            dbz_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!div_q) begin
                    hi_d = prod[2*N-1:N];
                    lo_d = prod[N-1:0];
                end else if (opnd_q == '0) begin
                    hi_d  = a_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            a_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            a_q     <= a_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.divByZero = dbz_q;
    assign bus.illegal   = ill_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule
